// File: rtl/wb_stage_pipelined.sv
// wb_stage_pipelined
//
// Registered writeback stage. Captures MEM-stage results into the MEM/WB
// register, selects the writeback source and drives the register-file write
// port. It also counts committed writebacks. Every output comes straight from
// a flop, so there is no combinational path from input to output.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous active-high reset (overrides Flush/Stall)
//   Stall        in   hold the MEM/WB register and RetireCount
//   Flush        in   load a bubble into the MEM/WB register
//   In_Valid     in   MEM-stage slot holds a real instruction
//   RegWrite     in   instruction writes the register file
//   WriteReg     in   destination register
//   MemToReg     in   source: 0 ALU, 1 load, 2 PC+LINK_OFFSET, 3 zero
//   ALUResult    in   ALU result
//   ReadData     in   raw data-memory read word
//   PC           in   instruction PC
//   LoadSize     in   0 byte, 1 half, 2 word32, 3 full width
//   LoadSigned   in   1 sign-extend, 0 zero-extend
//   ByteOffset   in   byte address of the load within ReadData
//   Out_Valid    out  WB slot holds a real instruction
//   WB_RegWrite  out  register-file write enable (never set for x0)
//   WB_WriteReg  out  register-file write address
//   WB_Data      out  register-file write data / forwarding value
//   RetireCount  out  count of committed writebacks (wraps)
//
// DATA_WIDTH must be 32 or 64.

module wb_stage_pipelined #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned LINK_OFFSET    = 8,
  parameter int unsigned CNT_WIDTH      = 32,
  localparam int unsigned OW            = $clog2(DATA_WIDTH / 8)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      In_Valid,
  input  logic                      RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WriteReg,
  input  logic [1:0]                MemToReg,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     ReadData,
  input  logic [DATA_WIDTH-1:0]     PC,
  input  logic [1:0]                LoadSize,
  input  logic                      LoadSigned,
  input  logic [OW-1:0]             ByteOffset,
  output logic                      Out_Valid,
  output logic                      WB_RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] WB_WriteReg,
  output logic [DATA_WIDTH-1:0]     WB_Data,
  output logic [CNT_WIDTH-1:0]      RetireCount
);

  // Writeback source encodings
  localparam logic [1:0] SrcAlu  = 2'd0;
  localparam logic [1:0] SrcLoad = 2'd1;
  localparam logic [1:0] SrcLink = 2'd2;

  // Load size encodings
  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  // Shift amounts are byte offsets scaled to bits
  localparam int unsigned SW = OW + 3;

  // ---------------------------------------------------------------------------
  // Load alignment
  // ---------------------------------------------------------------------------
  // Halfword and word lanes are naturally aligned. The low offset bits are
  // masked off rather than trapped, so a misaligned access simply reads the
  // lane that contains it.
  logic [OW-1:0] half_off;
  logic [OW-1:0] word_off;
  logic [SW-1:0] byte_sh;
  logic [SW-1:0] half_sh;
  logic [SW-1:0] word_sh;

  assign half_off = ByteOffset & ~OW'(1);
  assign word_off = ByteOffset & ~OW'(3);  // constant zero when DATA_WIDTH is 32
  assign byte_sh  = {ByteOffset, 3'b000};
  assign half_sh  = {half_off, 3'b000};
  assign word_sh  = {word_off, 3'b000};

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;

  assign byte_lane = 8'(ReadData >> byte_sh);
  assign half_lane = 16'(ReadData >> half_sh);
  assign word_lane = 32'(ReadData >> word_sh);

  logic [DATA_WIDTH-1:0] byte_ext;
  logic [DATA_WIDTH-1:0] half_ext;
  logic [DATA_WIDTH-1:0] word_ext;

  assign byte_ext = {{(DATA_WIDTH - 8){LoadSigned & byte_lane[7]}}, byte_lane};
  assign half_ext = {{(DATA_WIDTH - 16){LoadSigned & half_lane[15]}}, half_lane};

  // A word32 load on a 32-bit datapath is already full width; there is
  // nothing to extend.
  if (DATA_WIDTH > 32) begin : g_word_ext
    assign word_ext = {{(DATA_WIDTH - 32){LoadSigned & word_lane[31]}}, word_lane};
  end else begin : g_word_pass
    assign word_ext = word_lane;
  end

  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    load_data = ReadData;
    case (LoadSize)
      SzByte:  load_data = byte_ext;
      SzHalf:  load_data = half_ext;
      SzWord:  load_data = word_ext;
      default: load_data = ReadData;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback source select
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] link_pc;
  logic [DATA_WIDTH-1:0] wb_data_next;

  // Wraps modulo 2^DATA_WIDTH
  assign link_pc = PC + DATA_WIDTH'(LINK_OFFSET);

  always_comb begin
    wb_data_next = '0;
    case (MemToReg)
      SrcAlu:  wb_data_next = ALUResult;
      SrcLoad: wb_data_next = load_data;
      SrcLink: wb_data_next = link_pc;
      default: wb_data_next = '0;
    endcase
  end

  // Register 0 is hard-wired zero, so a write to it is suppressed here and
  // downstream forwarding never sees a bogus x0 producer.
  logic reg_write_next;

  assign reg_write_next = In_Valid & RegWrite & (WriteReg != '0);

  // ---------------------------------------------------------------------------
  // MEM/WB register and retire counter
  // ---------------------------------------------------------------------------
  // Priority: Reset > Flush > Stall > capture. A flush clears the slot but
  // leaves RetireCount alone, since nothing retired on that edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Out_Valid   <= 1'b0;
      WB_RegWrite <= 1'b0;
      WB_WriteReg <= '0;
      WB_Data     <= '0;
      RetireCount <= '0;
    end else if (Flush) begin
      Out_Valid   <= 1'b0;
      WB_RegWrite <= 1'b0;
      WB_WriteReg <= '0;
      WB_Data     <= '0;
    end else if (!Stall) begin
      // Fields are captured even for invalid slots; WB_RegWrite gates the write.
      Out_Valid   <= In_Valid;
      WB_RegWrite <= reg_write_next;
      WB_WriteReg <= WriteReg;
      WB_Data     <= wb_data_next;
      if (reg_write_next) begin
        RetireCount <= RetireCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_pipelined.sv
module tb_wb_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [1:0]  mem_to_reg;
  logic [1:0]  load_size;
  logic        load_signed;

  // 32-bit datapath inputs
  logic [31:0] alu_result;
  logic [31:0] read_data;
  logic [31:0] pc;
  logic [1:0]  byte_offset;

  // 64-bit datapath inputs
  logic [63:0] alu_result64;
  logic [63:0] read_data64;
  logic [63:0] pc64;
  logic [2:0]  byte_offset64;

  logic        out_valid, wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic [31:0] retire_count;

  logic        c_out_valid, c_wb_reg_write;
  logic [4:0]  c_wb_write_reg;
  logic [31:0] c_wb_data;
  logic [3:0]  c_retire_count;

  logic        w_out_valid, w_wb_reg_write;
  logic [4:0]  w_wb_write_reg;
  logic [63:0] w_wb_data;
  logic [31:0] w_retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage_pipelined u_dut (
    .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush), .In_Valid(in_valid),
    .RegWrite(reg_write), .WriteReg(write_reg), .MemToReg(mem_to_reg),
    .ALUResult(alu_result), .ReadData(read_data), .PC(pc), .LoadSize(load_size),
    .LoadSigned(load_signed), .ByteOffset(byte_offset), .Out_Valid(out_valid),
    .WB_RegWrite(wb_reg_write), .WB_WriteReg(wb_write_reg), .WB_Data(wb_data),
    .RetireCount(retire_count)
  );

  wb_stage_pipelined #(.CNT_WIDTH(4)) u_cnt4 (
    .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush), .In_Valid(in_valid),
    .RegWrite(reg_write), .WriteReg(write_reg), .MemToReg(mem_to_reg),
    .ALUResult(alu_result), .ReadData(read_data), .PC(pc), .LoadSize(load_size),
    .LoadSigned(load_signed), .ByteOffset(byte_offset), .Out_Valid(c_out_valid),
    .WB_RegWrite(c_wb_reg_write), .WB_WriteReg(c_wb_write_reg), .WB_Data(c_wb_data),
    .RetireCount(c_retire_count)
  );

  wb_stage_pipelined #(.DATA_WIDTH(64)) u_dw64 (
    .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush), .In_Valid(in_valid),
    .RegWrite(reg_write), .WriteReg(write_reg), .MemToReg(mem_to_reg),
    .ALUResult(alu_result64), .ReadData(read_data64), .PC(pc64), .LoadSize(load_size),
    .LoadSigned(load_signed), .ByteOffset(byte_offset64), .Out_Valid(w_out_valid),
    .WB_RegWrite(w_wb_reg_write), .WB_WriteReg(w_wb_write_reg), .WB_Data(w_wb_data),
    .RetireCount(w_retire_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and move 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic v, input logic rw,
                            input logic [4:0] wr, input logic [31:0] d,
                            input logic [31:0] cnt);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".regwrite"}, 64'(wb_reg_write), 64'(rw));
    check({tag, ".writereg"}, 64'(wb_write_reg), 64'(wr));
    check({tag, ".data"}, 64'(wb_data), 64'(d));
    check({tag, ".retire"}, 64'(retire_count), 64'(cnt));
  endtask

  // Watchdog: the sequence is purely directed, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1, "timeout");
  end

  logic [31:0] byte_exp [4];

  initial begin
    byte_exp[0] = 32'h0000_0022;
    byte_exp[1] = 32'h0000_007F;
    byte_exp[2] = 32'hFFFF_FFF1;
    byte_exp[3] = 32'hFFFF_FF80;

    // 1. Reset with random inputs
    rst           = 1'b1;
    stall         = 1'($urandom);
    flush         = 1'($urandom);
    in_valid      = 1'b1;
    reg_write     = 1'b1;
    write_reg     = 5'($urandom_range(1, 31));
    mem_to_reg    = 2'($urandom);
    load_size     = 2'($urandom);
    load_signed   = 1'($urandom);
    alu_result    = $urandom;
    read_data     = $urandom;
    pc            = $urandom;
    byte_offset   = 2'($urandom);
    alu_result64  = {$urandom, $urandom};
    read_data64   = {$urandom, $urandom};
    pc64          = {$urandom, $urandom};
    byte_offset64 = 3'($urandom);
    tick();
    tick();
    check_main("reset", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check("reset.cnt4", 64'(c_retire_count), 64'd0);
    check("reset.dw64.data", w_wb_data, 64'd0);

    rst        = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    mem_to_reg = 2'd0;
    alu_result = 32'h1234_ABCD;
    tick();
    check_main("alu", 1'b1, 1'b1, 5'd5, 32'h1234_ABCD, 32'd1);

    // 2. Load alignment on the 32-bit datapath
    mem_to_reg  = 2'd1;
    read_data   = 32'h80F1_7F22;
    load_size   = 2'd0;
    load_signed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_offset = 2'(i);
      tick();
      check($sformatf("lb_off%0d", i), 64'(wb_data), 64'(byte_exp[i]));
    end
    check("lb.retire", 64'(retire_count), 64'd5);

    load_size   = 2'd1;
    load_signed = 1'b0;
    byte_offset = 2'd2;
    tick();
    check("lhu_off2", 64'(wb_data), 64'h0000_80F1);

    load_signed = 1'b1;
    byte_offset = 2'd3;
    tick();
    check("lh_off3", 64'(wb_data), 64'hFFFF_80F1);

    load_size   = 2'd2;
    byte_offset = 2'd3;
    tick();
    check("lw_off3", 64'(wb_data), 64'h80F1_7F22);
    check("lw.retire", 64'(retire_count), 64'd8);

    // 3. Link wrap, zero source, x0 suppression, invalid slot
    mem_to_reg = 2'd2;
    pc         = 32'hFFFF_FFFC;
    tick();
    check("link_wrap", 64'(wb_data), 64'h0000_0004);

    mem_to_reg = 2'd3;
    alu_result = 32'hDEAD_BEEF;
    tick();
    check_main("zero_src", 1'b1, 1'b1, 5'd5, 32'd0, 32'd10);

    mem_to_reg = 2'd0;
    write_reg  = 5'd0;
    tick();
    check_main("x0", 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd10);

    in_valid  = 1'b0;
    write_reg = 5'd7;
    tick();
    check_main("invalid", 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF, 32'd10);

    // 4. Stall holds everything, then Stall+Flush bubbles
    in_valid   = 1'b1;
    write_reg  = 5'd9;
    alu_result = 32'hCAFE_F00D;
    tick();
    check_main("pre_stall", 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 32'd11);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_reg  = 5'(3 + i);
      alu_result = 32'h1111_1111 * 32'(i + 1);
      mem_to_reg = 2'(i);
      tick();
      check_main($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 32'd11);
    end

    flush = 1'b1;
    tick();
    check_main("stall_flush", 1'b0, 1'b0, 5'd0, 32'd0, 32'd11);

    // 5. Reset beats Stall, then 4-bit counter wrap
    flush = 1'b0;
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    check_main("reset_stall", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check("reset_stall.cnt4", 64'(c_retire_count), 64'd0);

    rst        = 1'b0;
    stall      = 1'b0;
    in_valid   = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd1;
    mem_to_reg = 2'd0;
    for (int i = 1; i <= 17; i++) begin
      alu_result = 32'(i);
      tick();
      check($sformatf("cnt4_%0d", i), 64'(c_retire_count), 64'(i % 16));
      check($sformatf("cnt32_%0d", i), 64'(retire_count), 64'(i));
    end

    // 6. 64-bit datapath loads
    mem_to_reg    = 2'd1;
    read_data64   = 64'h8877_6655_4433_2211;
    load_size     = 2'd2;
    load_signed   = 1'b1;
    byte_offset64 = 3'd4;
    tick();
    check("dw64.lw_off4", w_wb_data, 64'hFFFF_FFFF_8877_6655);

    byte_offset64 = 3'd6;
    load_signed   = 1'b0;
    tick();
    check("dw64.lwu_off6", w_wb_data, 64'h0000_0000_8877_6655);

    load_size = 2'd3;
    tick();
    check("dw64.full", w_wb_data, 64'h8877_6655_4433_2211);

    load_size     = 2'd0;
    load_signed   = 1'b1;
    byte_offset64 = 3'd7;
    tick();
    check("dw64.lb_off7", w_wb_data, 64'hFFFF_FFFF_FFFF_FF88);

    load_size     = 2'd1;
    byte_offset64 = 3'd2;
    tick();
    check("dw64.lh_off2", w_wb_data, 64'h0000_0000_0000_4433);

    mem_to_reg = 2'd2;
    pc64       = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    check("dw64.link_wrap", w_wb_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
